// File: rtl/dmem_pkg.sv
// Shared types and helpers for the MEM-stage data memory: access sizes,
// funct3 encodings, lane masks, load extension and alignment checks.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  // Byte lanes touched by an access of this size starting at lane offset.
  function automatic logic [7:0] lane_mask(size_e size, logic [2:0] offset);
    logic [7:0] m;
    case (size)
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      SZ_W:    m = 8'h0f;
      default: m = 8'hff;
    endcase
    return m << offset;
  endfunction

  function automatic logic [63:0] extend(logic [63:0] word, size_e size,
                                         logic [2:0] offset, logic is_unsigned);
    logic [63:0] sh;
    logic [63:0] res;
    sh = word >> {offset, 3'b000};
    case (size)
      SZ_B:    res = is_unsigned ? {56'h0, sh[7:0]}  : {{56{sh[7]}}, sh[7:0]};
      SZ_H:    res = is_unsigned ? {48'h0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
      SZ_W:    res = is_unsigned ? {32'h0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
      default: res = sh;
    endcase
    return res;
  endfunction

  function automatic logic is_misaligned(size_e size, logic [2:0] addr);
    logic mis;
    case (size)
      SZ_H:    mis = addr[0];
      SZ_W:    mis = |addr[1:0];
      SZ_D:    mis = |addr;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// Byte-lane data array: one 8-bit memory per lane, per-lane write enable and
// a read register that only updates when a read is requested.
module dmem_bank #(
  parameter int LANES = 4,
  parameter int IDX_W = 7
) (
  input  logic                 clk,
  input  logic [LANES-1:0]     we,
  input  logic                 re,
  input  logic [IDX_W-1:0]     idx,
  input  logic [LANES*8-1:0]   wdata,
  output logic [LANES*8-1:0]   rdata
);

  localparam int DEPTH = 2 ** IDX_W;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] rd;

    always_ff @(posedge clk) begin
      if (we[l]) mem[idx] <= wdata[8*l +: 8];
      if (re)    rd <= mem[idx];
    end

    assign rdata[8*l +: 8] = rd;
  end

endmodule

// File: rtl/dmem_lsu.sv
// MEM-stage load/store unit: decodes funct3, aligns store lanes, extends load
// data and returns every request through a one-deep registered response slot.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 32,
  parameter int ERRCNT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [2:0]          req_funct3,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic [ERRCNT_W-1:0] err_count
);

  localparam int LANES = DATA_W / 8;
  localparam int OFS_W = $clog2(LANES);
  localparam int IDX_W = ADDR_W - OFS_W;
  localparam bit WIDE  = (DATA_W == 64);

  // Handshake: a request transfers when req_valid && req_ready; a response
  // transfers when rsp_valid && rsp_ready; the slot refills in the same edge.
  logic              accept;
  logic [OFS_W-1:0]  ofs;
  logic [2:0]        ofs3;
  logic [IDX_W-1:0]  idx;
  size_e             size;
  logic              legal;
  logic              req_err;
  logic              store_en;
  logic              load_en;
  logic [7:0]        mask8;
  logic [LANES-1:0]  bank_we;
  logic [DATA_W-1:0] wdata_sh;
  logic [DATA_W-1:0] bank_rdata;
  logic [63:0]       ext;

  state_e state;
  state_e state_nx;

  logic   err_q;
  logic   load_q;
  size_e  size_q;
  logic [2:0] ofs_q;
  logic   uns_q;

  assign idx  = req_addr[ADDR_W-1:OFS_W];
  assign ofs  = req_addr[OFS_W-1:0];
  assign ofs3 = 3'(ofs);
  assign size = size_e'(req_funct3[1:0]);

  // Doubleword and WU encodings only exist on the 64-bit data path.
  always_comb begin
    legal = 1'b0;
    if (req_we) legal = !req_funct3[2] && ((req_funct3 != F3_SD) || WIDE);
    else        legal = (req_funct3 != 3'b111) &&
                        (((req_funct3 != F3_LD) && (req_funct3 != F3_LWU)) || WIDE);
  end

  assign req_err   = !legal || is_misaligned(size, req_addr[2:0]);
  assign req_ready = (state == ST_EMPTY) || rsp_ready;
  assign accept    = req_valid && req_ready;
  assign store_en  = accept && req_we && !req_err && !reset;
  assign load_en   = accept && !req_we && !req_err;
  assign mask8     = lane_mask(size, ofs3);
  assign bank_we   = store_en ? LANES'(mask8) : '0;
  assign wdata_sh  = req_wdata << {ofs, 3'b000};

  dmem_bank #(
    .LANES (LANES),
    .IDX_W (IDX_W)
  ) u_bank (
    .clk   (clk),
    .we    (bank_we),
    .re    (load_en),
    .idx   (idx),
    .wdata (wdata_sh),
    .rdata (bank_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_EMPTY;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_EMPTY: if (accept) state_nx = ST_FULL;
      ST_FULL:  if (rsp_ready && !accept) state_nx = ST_EMPTY;
      default:  state_nx = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q  <= 1'b0;
      load_q <= 1'b0;
      size_q <= SZ_B;
      ofs_q  <= 3'd0;
      uns_q  <= 1'b0;
    end else if (accept) begin
      err_q  <= req_err;
      load_q <= load_en;
      size_q <= size;
      ofs_q  <= ofs3;
      uns_q  <= req_funct3[2];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                          err_count <= '0;
    else if (accept && req_err && (err_count != '1))    err_count <= err_count + 1'b1;
  end

  // Extension runs on the registered read word, so a held response stays put.
  assign ext       = extend(64'(bank_rdata), size_q, ofs_q, uns_q);
  assign rsp_valid = (state == ST_FULL);
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_rdata = (rsp_valid && load_q) ? DATA_W'(ext) : '0;

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: a 32-bit instance and a 64-bit instance with a 2-bit
// error counter, checked against a byte-array reference model.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid [2];
  logic        req_we    [2];
  logic [2:0]  req_funct3[2];
  logic [8:0]  req_addr  [2];
  logic [63:0] req_wdata [2];
  logic        rsp_ready [2];
  logic        req_ready [2];
  logic        rsp_valid [2];
  logic        rsp_err   [2];
  logic [31:0] rdata32;
  logic [63:0] rdata64;
  logic [15:0] ecnt32;
  logic [1:0]  ecnt64;

  logic [64:0] exp_q0[$];
  logic [64:0] exp_q1[$];
  logic [7:0]  mb [2][512];
  int          emc [2];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_pops   = 0;
  logic [64:0] last_rsp;
  logic        last_ready;

  always #5 clk = ~clk;

  dmem_lsu #(.ADDR_W(9), .DATA_W(32), .ERRCNT_W(16)) u_dut32 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_funct3(req_funct3[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0][31:0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rdata32),
    .rsp_err(rsp_err[0]), .err_count(ecnt32)
  );

  dmem_lsu #(.ADDR_W(9), .DATA_W(64), .ERRCNT_W(2)) u_dut64 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_funct3(req_funct3[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rdata64),
    .rsp_err(rsp_err[1]), .err_count(ecnt64)
  );

  // Reference: memory as bytes; a request is a byte count plus sign rule.
  task automatic model_req(input int d, input logic we, input logic [2:0] f3,
                           input logic [8:0] addr, input logic [63:0] wd);
    int nb;
    bit ok;
    logic [63:0] v;
    logic [64:0] e;
    nb = 1 << f3[1:0];
    if (we) ok = (f3 <= 3'd3) && (f3 != 3'd3 || d == 1);
    else    ok = (f3 != 3'd7) && ((f3 != 3'd3 && f3 != 3'd6) || d == 1);
    if (!ok || (int'(addr) % nb) != 0) begin
      if (emc[d] < (d == 1 ? 3 : 65535)) emc[d]++;
      e = {1'b1, 64'h0};
    end else if (we) begin
      for (int i = 0; i < nb; i++) mb[d][int'(addr) + i] = wd[8*i +: 8];
      e = 65'h0;
    end else begin
      v = 64'h0;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = mb[d][int'(addr) + i];
      if (!f3[2] && nb < 8 && v[8*nb-1])
        for (int i = 8 * nb; i < 64; i++) v[i] = 1'b1;
      if (d == 0) v[63:32] = 32'h0;
      e = {1'b0, v};
    end
    if (d == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  // Driver plus scoreboard for one cycle of one instance.
  task automatic step(input int d, input logic v, input logic we, input logic [2:0] f3,
                      input logic [8:0] addr, input logic [63:0] wd, input logic rr);
    logic [64:0] front;
    logic [64:0] got;
    bit ev;
    int cnt;
    req_valid[d] = v; req_we[d] = we; req_funct3[d] = f3;
    req_addr[d] = addr; req_wdata[d] = wd; rsp_ready[d] = rr;
    req_valid[1-d] = 1'b0; rsp_ready[1-d] = 1'b1;
    @(negedge clk);
    ev  = (d == 1) ? (exp_q1.size() > 0) : (exp_q0.size() > 0);
    cnt = (d == 1) ? int'(ecnt64) : int'(ecnt32);
    n_checks++;
    if (rsp_valid[d] !== ev) $display("FAIL rsp_valid dut%0d got %b want %b", d, rsp_valid[d], ev);
    else n_pass++;
    n_checks++;
    if (req_ready[d] !== (!ev || rr))
      $display("FAIL req_ready dut%0d got %b want %b", d, req_ready[d], (!ev || rr));
    else n_pass++;
    n_checks++;
    if (cnt != emc[d]) $display("FAIL err_count dut%0d got %0d want %0d", d, cnt, emc[d]);
    else n_pass++;
    if (ev) begin
      front = (d == 1) ? exp_q1[0] : exp_q0[0];
      got   = {rsp_err[d], ((d == 1) ? rdata64 : {32'h0, rdata32})};
      n_checks++;
      if (got !== front) $display("FAIL rsp dut%0d got %h want %h", d, got, front);
      else n_pass++;
      if (rr) begin
        if (d == 1) void'(exp_q1.pop_front());
        else        void'(exp_q0.pop_front());
        last_rsp = got;
        n_pops++;
      end
    end
    last_ready = req_ready[d];
    if (v && (!ev || rr)) model_req(d, we, f3, addr, wd);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int d, input int n);
    for (int i = 0; i < n; i++) step(d, 1'b0, 1'b0, 3'd0, 9'd0, 64'd0, 1'b1);
  endtask

  task automatic test_reset;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_funct3[d] = 3'd0;
      req_addr[d] = 9'd0; req_wdata[d] = 64'd0; rsp_ready[d] = 1'b1;
      emc[d] = 0;
    end
    reset = 1'b1;
    #3;
    n_checks++;
    if ({rsp_valid[0], rsp_err[0], rdata32, ecnt32} !== 50'h0 ||
        {rsp_valid[1], rsp_err[1], rdata64, ecnt64} !== 68'h0)
      $display("FAIL reset_outputs got %b%b%h%h %b%b%h%h want 0", rsp_valid[0], rsp_err[0],
               rdata32, ecnt32, rsp_valid[1], rsp_err[1], rdata64, ecnt64);
    else n_pass++;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    n_checks++;
    if (req_ready[0] !== 1'b1 || req_ready[1] !== 1'b1)
      $display("FAIL reset_ready got %b%b want 11", req_ready[0], req_ready[1]);
    else n_pass++;
  endtask

  task automatic test_init;
    for (int a = 0; a < 512; a += 4) step(0, 1'b1, 1'b1, 3'b010, 9'(a), {32'h0, $urandom}, 1'b1);
    idle(0, 2);
    for (int a = 0; a < 512; a += 8) step(1, 1'b1, 1'b1, 3'b011, 9'(a), {$urandom, $urandom}, 1'b1);
    idle(1, 2);
  endtask

  task automatic test_basic32;
    logic [8:0]  ta [4];
    logic [2:0]  tf [4];
    logic [31:0] te [4];
    ta = '{9'h13, 9'h13, 9'h12, 9'h10};
    tf = '{3'b000, 3'b100, 3'b001, 3'b010};
    te = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'hDEADBEEF};
    step(0, 1'b1, 1'b1, 3'b010, 9'h10, 64'hDEADBEEF, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(0, 1'b1, 1'b0, tf[i], ta[i], 64'h0, 1'b1);
      idle(0, 1);
      n_checks++;
      if (last_rsp !== {33'h0, te[i]}) $display("FAIL basic32_%0d got %h want %h", i, last_rsp, te[i]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    bit ready_ok = 1'b1;
    step(0, 1'b1, 1'b1, 3'b000, 9'h11, 64'hA5, 1'b1);
    ready_ok &= last_ready;
    step(0, 1'b1, 1'b0, 3'b010, 9'h10, 64'h0, 1'b1);
    ready_ok &= last_ready;
    step(0, 1'b1, 1'b1, 3'b001, 9'h20, 64'h7F01, 1'b1);
    ready_ok &= last_ready;
    step(0, 1'b1, 1'b0, 3'b001, 9'h20, 64'h0, 1'b1);
    ready_ok &= last_ready;
    idle(0, 1);
    n_checks++;
    if (!ready_ok) $display("FAIL b2b_ready got 0 want 1");
    else n_pass++;
    n_checks++;
    if (last_rsp !== 65'h7F01) $display("FAIL b2b_lh got %h want 7f01", last_rsp);
    else n_pass++;
    step(0, 1'b1, 1'b0, 3'b010, 9'h10, 64'h0, 1'b1);
    idle(0, 1);
    n_checks++;
    if (last_rsp !== 65'hDEADA5EF) $display("FAIL b2b_merge got %h want deada5ef", last_rsp);
    else n_pass++;
  endtask

  task automatic test_misaligned;
    step(0, 1'b1, 1'b0, 3'b010, 9'h12, 64'h0, 1'b1);
    step(0, 1'b1, 1'b1, 3'b001, 9'h13, 64'hFFFF, 1'b1);
    idle(0, 1);
    n_checks++;
    if (last_rsp !== {1'b1, 64'h0}) $display("FAIL misaligned_rsp got %h want 1_0", last_rsp);
    else n_pass++;
    step(0, 1'b1, 1'b0, 3'b010, 9'h10, 64'h0, 1'b1);
    idle(0, 1);
    n_checks++;
    if (last_rsp !== 65'hDEADA5EF || ecnt32 !== 16'd2)
      $display("FAIL misaligned_mem got %h cnt %0d want deada5ef cnt 2", last_rsp, ecnt32);
    else n_pass++;
    step(0, 1'b1, 1'b0, 3'b011, 9'h10, 64'h0, 1'b1);
    idle(0, 1);
    n_checks++;
    if (last_rsp !== {1'b1, 64'h0} || ecnt32 !== 16'd3)
      $display("FAIL illegal_ld32 got %h cnt %0d want 1_0 cnt 3", last_rsp, ecnt32);
    else n_pass++;
  endtask

  task automatic test_backpressure;
    int pops0;
    bit held_ok = 1'b1;
    pops0 = n_pops;
    step(0, 1'b1, 1'b0, 3'b010, 9'h10, 64'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(0, 1'b1, 1'b1, 3'b010, 9'h40, 64'h1234, 1'b0);
      held_ok &= !last_ready;
    end
    step(0, 1'b1, 1'b0, 3'b000, 9'h10, 64'h0, 1'b1);
    idle(0, 1);
    n_checks++;
    if (!held_ok) $display("FAIL bp_ready got 1 want 0");
    else n_pass++;
    n_checks++;
    if (n_pops - pops0 != 2 || last_rsp !== 65'hFFFFFFEF)
      $display("FAIL bp_handover got pops %0d rsp %h want pops 2 rsp ffffffef", n_pops - pops0, last_rsp);
    else n_pass++;
  endtask

  task automatic test_wide64;
    logic [2:0]  tf [3];
    logic [8:0]  ta [3];
    logic [63:0] te [3];
    tf = '{3'b110, 3'b010, 3'b011};
    ta = '{9'h0C, 9'h08, 9'h08};
    te = '{64'h0000000001234567, 64'hFFFFFFFF89ABCDEF, 64'h0123456789ABCDEF};
    step(1, 1'b1, 1'b1, 3'b011, 9'h08, 64'h0123456789ABCDEF, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1, 1'b1, 1'b0, tf[i], ta[i], 64'h0, 1'b1);
      idle(1, 1);
      n_checks++;
      if (last_rsp !== {1'b0, te[i]}) $display("FAIL wide64_%0d got %h want %h", i, last_rsp, te[i]);
      else n_pass++;
    end
  endtask

  task automatic test_random(input int d);
    logic [2:0] f3;
    logic [8:0] a;
    logic we;
    for (int i = 0; i < 300; i++) begin
      we = 1'($urandom_range(0, 1));
      f3 = we ? (($urandom_range(0, 7) == 0) ? 3'd7 : 3'($urandom_range(0, 3))) : 3'($urandom_range(0, 7));
      a  = 9'($urandom_range(0, 511));
      if ($urandom_range(0, 3) != 0) a = a & ~9'((1 << f3[1:0]) - 1);
      step(d, $urandom_range(0, 3) != 0, we, f3, a, {$urandom, $urandom}, $urandom_range(0, 3) != 0);
    end
    idle(d, 3);
  endtask

  task automatic test_reset_mid;
    step(0, 1'b1, 1'b1, 3'b010, 9'h20, 64'h11223344, 1'b1);
    step(0, 1'b1, 1'b0, 3'b010, 9'h10, 64'h0, 1'b0);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_funct3[0] = 3'b010;
    req_addr[0] = 9'h20; req_wdata[0] = 64'hFFFFFFFF; rsp_ready[0] = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (rsp_valid[0] !== 1'b0 || rdata32 !== 32'h0 || rsp_err[0] !== 1'b0 || ecnt32 !== 16'h0)
      $display("FAIL reset_mid got v%b d%h e%b c%0d want all 0", rsp_valid[0], rdata32, rsp_err[0], ecnt32);
    else n_pass++;
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    reset = 1'b0;
    exp_q0.delete(); exp_q1.delete();
    emc[0] = 0; emc[1] = 0;
    step(0, 1'b1, 1'b0, 3'b010, 9'h20, 64'h0, 1'b1);
    idle(0, 1);
    n_checks++;
    if (last_rsp !== 65'h11223344) $display("FAIL reset_store_blocked got %h want 11223344", last_rsp);
    else n_pass++;
  endtask

  task automatic test_saturate;
    for (int i = 0; i < 5; i++) step(1, 1'b1, 1'b0, 3'b010, 9'(1 + 8 * i), 64'h0, 1'b1);
    idle(1, 1);
    n_checks++;
    if (ecnt64 !== 2'd3) $display("FAIL saturate got %0d want 3", ecnt64);
    else n_pass++;
  endtask

  initial begin
    test_reset;
    test_init;
    test_basic32;
    test_back_to_back;
    test_misaligned;
    test_backpressure;
    test_wide64;
    test_random(0);
    test_random(1);
    test_reset_mid;
    test_saturate;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
